dope_motion: RTL
================

# dope_motion

Player ("dope") motion controller: converts debounced button levels into the sprite anchor position `dope_x`/`dope_y` and the `jump` flag consumed by the floor collision/render block, and reacts to that block's combinational `grounded` return. Runs walk, jump-rise, gravity-fall and respawn physics on a divided tick. Sits between the input debouncers and the floor/sprite renderers in the game top level.

## Interface
- TICK_DIV, 1048576: clk cycles per physics tick (≥2)
- WALK_STEP, 2: horizontal pixels per tick
- JUMP_V0, 11: initial upward velocity (px/tick)
- GRAVITY, 1: velocity change per tick
- MAX_FALL, 3: fall-speed cap; must be ≤3 so a fall never skips the 3-px grounded window
- X_MIN, 65 / X_MAX, 627: clamp range of `dope_x` (right edge of 52-px sprite)
- Y_MIN, 60 / Y_MAX, 479: ceiling clamp / fall-out limit of `dope_y` (feet row)
- X_START, 65 / Y_START, 448: reset and respawn position
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- restart  in  1  single-cycle pulse: return to start position (level change)
- btn_left, btn_right, btn_jump  in  1 each  debounced button levels
- grounded  in  1  from floor block; combinational on current `dope_x`/`dope_y`/`jump`
- dope_x, dope_y  out  10 each  registered sprite anchor
- jump  out  1  high only in RISE
- facing  out  1  1 = right, 0 = left
- respawn  out  1  one-cycle pulse on fall-out

## Operation
- Tick counter 0..TICK_DIV-1; `tick` asserted in the cycle count==TICK_DIV-1, then wraps to 0. All position/state updates occur only in tick cycles, except jump-request capture.
- jump_req: set on any btn_jump rising edge (edge register on btn_jump); cleared at every tick (consumed or discarded).
- States: GROUND, RISE, FALL; vy unsigned 5 bits.
- GROUND at tick: jump_req → RISE, vy←JUMP_V0, jump←1, y unchanged. Else !grounded → FALL, vy←0. Else stay.
- RISE at tick: if y−vy < Y_MIN: y←Y_MIN, FALL, vy←0, jump←0. Else y←y−vy, vy←vy−GRAVITY; if new vy==0: FALL, jump←0. Default total rise 66 px over 11 ticks.
- FALL at tick: grounded → GROUND, vy←0, y unchanged. Else vy←min(vy+GRAVITY, MAX_FALL), y←y+new vy; if result > Y_MAX: respawn (x←X_START, y←Y_START, FALL, vy←0, respawn pulse).
- Horizontal, every tick in every state: left only → x←max(x−WALK_STEP, X_MIN), facing←0; right only → x←min(x+WALK_STEP, X_MAX), facing←1; both or neither → no change. Arithmetic in 11 bits before clamp; no wrap.
- restart (any cycle): x←X_START, y←Y_START, FALL, vy←0, jump←0, jump_req←0, tick counter←0; facing held. Priority: reset_n > restart > tick update.
- Tick coinciding with fall-out and horizontal move: respawn wins; x←X_START.

## Timing
- Reset values: dope_x=X_START, dope_y=Y_START, jump=0, facing=1, respawn=0, state FALL, vy=0, jump_req=0, counter=0.
- Outputs registered; update visible the cycle after the tick cycle.
- grounded is sampled in the tick cycle against already-registered outputs; no extra latency.
- btn_jump edge one cycle before tick is honoured at that tick; edge in the tick cycle itself is honoured at the next tick.
- Reset or restart mid-jump aborts immediately; jump←0 next cycle.

## Test plan
- Reset, TICK_DIV=4, grounded=1: outputs 65/448/jump=0/facing=1; after first tick state GROUND, y stays 448.
- btn_right held 10 ticks from x=65 → x=85, facing=1; from x=625 two ticks → 627 and holds; both buttons → x unchanged.
- GROUND, btn_jump pulse → next tick jump=1; 11 RISE ticks y 448→437→…→382, jump=0 after 11th; with grounded=0 falls 1,2,3,3 px per tick (383,385,388,391).
- GROUND, grounded drops → FALL next tick; grounded reasserted at y=451 → GROUND, y frozen; btn_jump pulsed during FALL ignored (no RISE).
- grounded=0 at y=478 falling at vy=3 → respawn pulse one cycle, x=65, y=448, state FALL.
- Mid-RISE restart pulse → 65/448, jump=0 next cycle; reset_n low mid-RISE → all reset values; RISE from y=64 → y clamps 60, FALL.

Source files
------------

// File: rtl/dope_motion.sv
// dope_motion: player motion controller (walk, jump, gravity, respawn).
// Ports: clk, reset_n, restart, btn_left/right/jump, grounded -> dope_x/y, jump, facing, respawn.
module dope_motion #(
  parameter int TICK_DIV  = 1048576,
  parameter int WALK_STEP = 2,
  parameter int JUMP_V0   = 11,
  parameter int GRAVITY   = 1,
  parameter int MAX_FALL  = 3,
  parameter int X_MIN     = 65,
  parameter int X_MAX     = 627,
  parameter int Y_MIN     = 60,
  parameter int Y_MAX     = 479,
  parameter int X_START   = 65,
  parameter int Y_START   = 448
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       grounded,
  output logic [9:0] dope_x,
  output logic [9:0] dope_y,
  output logic       jump,
  output logic       facing,
  output logic       respawn
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  localparam logic [10:0] XMIN11 = 11'(X_MIN);
  localparam logic [10:0] XMAX11 = 11'(X_MAX);
  localparam logic [10:0] YMIN11 = 11'(Y_MIN);
  localparam logic [10:0] YMAX11 = 11'(Y_MAX);
  localparam logic [10:0] WS11   = 11'(WALK_STEP);
  localparam logic [9:0]  XS10   = 10'(X_START);
  localparam logic [9:0]  YS10   = 10'(Y_START);
  localparam logic [4:0]  JV0    = 5'(JUMP_V0);
  localparam logic [4:0]  GRV    = 5'(GRAVITY);
  localparam logic [5:0]  MXF6   = 6'(MAX_FALL);

  typedef enum logic [1:0] {
    S_GROUND = 2'd0,
    S_RISE   = 2'd1,
    S_FALL   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          tick;
  logic          jbtn_q;
  logic          jreq_q;
  logic          jump_rise;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [4:0]    vy_q, vy_d;
  logic          facing_q, facing_d;
  logic          respawn_q;
  logic          fall_out;

  logic [10:0]   x11, y11;
  logic [10:0]   y_fall;
  logic [5:0]    vy_sum;
  logic [4:0]    vy_new;

  assign tick      = (cnt_q == CNT_LAST);
  assign jump_rise = btn_jump & ~jbtn_q;
  assign x11       = {1'b0, x_q};
  assign y11       = {1'b0, y_q};

  always_ff @(posedge clk) begin
    if (!reset_n) jbtn_q <= 1'b0;
    else          jbtn_q <= btn_jump;
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FALL;
      cnt_q     <= '0;
      jreq_q    <= 1'b0;
      x_q       <= XS10;
      y_q       <= YS10;
      vy_q      <= '0;
      facing_q  <= 1'b1;
      respawn_q <= 1'b0;
    end else if (restart) begin
      state_q   <= S_FALL;
      cnt_q     <= '0;
      jreq_q    <= 1'b0;
      x_q       <= XS10;
      y_q       <= YS10;
      vy_q      <= '0;
      respawn_q <= 1'b0;
    end else begin
      respawn_q <= 1'b0;
      if (tick) begin
        cnt_q    <= '0;
        // an edge arriving in the tick cycle waits for the next tick
        jreq_q   <= jump_rise;
        facing_q <= facing_d;
        if (fall_out) begin
          state_q   <= S_FALL;
          x_q       <= XS10;
          y_q       <= YS10;
          vy_q      <= '0;
          respawn_q <= 1'b1;
        end else begin
          state_q <= state_d;
          x_q     <= x_d;
          y_q     <= y_d;
          vy_q    <= vy_d;
        end
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        jreq_q <= jreq_q | jump_rise;
      end
    end
  end

  // Next-state and next-position logic, applied only on tick
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    vy_d     = vy_q;
    x_d      = x_q;
    facing_d = facing_q;
    fall_out = 1'b0;
    y_fall   = y11;
    vy_sum   = {1'b0, vy_q} + {1'b0, GRV};
    vy_new   = (vy_sum > MXF6) ? MXF6[4:0] : vy_sum[4:0];

    unique case (1'b1)
      btn_left && !btn_right: begin
        facing_d = 1'b0;
        if (x11 < XMIN11 + WS11) x_d = XMIN11[9:0];
        else                     x_d = 10'(x11 - WS11);
      end
      btn_right && !btn_left: begin
        facing_d = 1'b1;
        if (x11 + WS11 > XMAX11) x_d = XMAX11[9:0];
        else                     x_d = 10'(x11 + WS11);
      end
      default: begin
        x_d = x_q;
      end
    endcase

    case (state_q)
      S_GROUND: begin
        if (jreq_q) begin
          state_d = S_RISE;
          vy_d    = JV0;
        end else if (!grounded) begin
          state_d = S_FALL;
          vy_d    = '0;
        end
      end
      S_RISE: begin
        if (y11 < YMIN11 + {6'd0, vy_q}) begin
          y_d     = YMIN11[9:0];
          state_d = S_FALL;
          vy_d    = '0;
        end else begin
          y_d = 10'(y11 - {6'd0, vy_q});
          if (vy_q <= GRV) begin
            vy_d    = '0;
            state_d = S_FALL;
          end else begin
            vy_d = vy_q - GRV;
          end
        end
      end
      S_FALL: begin
        if (grounded) begin
          state_d = S_GROUND;
          vy_d    = '0;
        end else begin
          vy_d   = vy_new;
          y_fall = y11 + {6'd0, vy_new};
          y_d    = y_fall[9:0];
          if (y_fall > YMAX11) fall_out = 1'b1;
        end
      end
      default: begin
        state_d = S_FALL;
        vy_d    = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    dope_x  = x_q;
    dope_y  = y_q;
    jump    = (state_q == S_RISE);
    facing  = facing_q;
    respawn = respawn_q;
  end

endmodule
